// File: rtl/eth_pattern_matcher.sv
// eth_pattern_matcher: multi-pattern masked byte matcher on a TEMAC rx stream.
// Compares the first PATTERN_LEN bytes of each frame against NUM_PATTERNS
// masked patterns and queues {match bitmap, length, SOF timestamp} events.
// Optional feature macro: ETH_PATTERN_MATCHER_DROP_CNT_EN enables the
// saturating drop counter; without it drop_count is tied to zero.
module eth_pattern_matcher #(
    parameter int NUM_PATTERNS = 4,
    parameter int PATTERN_LEN  = 64,
    parameter int EVT_DEPTH    = 4,
    localparam int SEL_W  = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1,
    localparam int ADDR_W = $clog2(PATTERN_LEN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [SEL_W-1:0]        cfg_sel,
    input  logic [ADDR_W-1:0]       cfg_addr,
    input  logic [7:0]              cfg_data,
    input  logic [7:0]              cfg_mask,
    input  logic [NUM_PATTERNS-1:0] cfg_enable,
    input  logic [7:0]              s_axis_tdata,
    input  logic                    s_axis_tuser,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    input  logic [63:0]             current_time,
    input  logic                    time_running,
    output logic                    m_evt_valid,
    input  logic                    m_evt_ready,
    output logic [NUM_PATTERNS-1:0] m_evt_match,
    output logic [15:0]             m_evt_length,
    output logic [63:0]             m_evt_time,
    output logic [31:0]             drop_count
);

    localparam int PW = $clog2(EVT_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(EVT_DEPTH);
    localparam logic [15:0]   PLEN_C  = 16'(PATTERN_LEN);

    typedef enum logic [1:0] {SYNC, IDLE, FRAME} state_t;

    // Pattern store: {mask, data} per pattern byte, not reset
    logic [15:0] pat_mem [NUM_PATTERNS][PATTERN_LEN];

    state_t                  state_q, state_d;
    logic [NUM_PATTERNS-1:0] flags_q, flags_d;
    logic [15:0]             len_q, len_d;
    logic [63:0]             time_q, time_d;
    logic                    run_q, run_d;
    logic [NUM_PATTERNS-1:0] en_q, en_d;

    logic                    fin_v_q, fin_v_d;
    logic [NUM_PATTERNS-1:0] fin_match_q, fin_match_d;
    logic [15:0]             fin_len_q, fin_len_d;
    logic [63:0]             fin_time_q, fin_time_d;

    logic [ADDR_W-1:0]       cmp_off;
    logic                    cmp_in_range;
    logic [NUM_PATTERNS-1:0] cmp_hit;
    logic                    frame_end;

    logic [NUM_PATTERNS-1:0] evt_match_mem [EVT_DEPTH];
    logic [15:0]             evt_len_mem   [EVT_DEPTH];
    logic [63:0]             evt_time_mem  [EVT_DEPTH];
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    evt_pop, evt_full, evt_push;

    // Pattern byte writes; guard keeps non-power-of-two pattern counts in range
    always_ff @(posedge clk) begin
        if (cfg_we && (32'(cfg_sel) < NUM_PATTERNS)) begin
            pat_mem[cfg_sel][cfg_addr] <= {cfg_mask, cfg_data};
        end
    end

    // The length counter doubles as the byte offset: both load to 1 on the
    // first byte and advance together, so one counter serves both roles.
    always_comb begin
        cmp_off      = (state_q == FRAME) ? len_q[ADDR_W-1:0] : '0;
        cmp_in_range = (state_q != FRAME) || (len_q < PLEN_C);
        cmp_hit      = '0;
        for (int unsigned p = 0; p < NUM_PATTERNS; p++) begin
            cmp_hit[SEL_W'(p)] =
                (((s_axis_tdata ^ pat_mem[SEL_W'(p)][cmp_off][7:0])
                  & pat_mem[SEL_W'(p)][cmp_off][15:8]) == 8'h00);
        end
    end

    // Parser next-state, per-frame accumulation and finalise staging
    always_comb begin
        state_d     = state_q;
        flags_d     = flags_q;
        len_d       = len_q;
        time_d      = time_q;
        run_d       = run_q;
        en_d        = en_q;
        fin_v_d     = 1'b0;
        fin_match_d = fin_match_q;
        fin_len_d   = fin_len_q;
        fin_time_d  = fin_time_q;
        frame_end   = 1'b0;
        case (state_q)
            SYNC: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (s_axis_tvalid) begin
                    flags_d   = cmp_hit;
                    len_d     = 16'd1;
                    time_d    = current_time;
                    run_d     = time_running;
                    en_d      = cfg_enable;
                    frame_end = s_axis_tlast;
                    state_d   = s_axis_tlast ? IDLE : FRAME;
                end
            end
            FRAME: begin
                if (s_axis_tvalid) begin
                    if (cmp_in_range) begin
                        flags_d = flags_q & cmp_hit;
                    end
                    len_d = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
                    if (s_axis_tlast) begin
                        frame_end = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = SYNC;
        endcase
        if (frame_end) begin
            fin_match_d = flags_d & en_d;
            fin_len_d   = len_d;
            fin_time_d  = time_d;
            fin_v_d     = (|(flags_d & en_d)) && !s_axis_tuser && run_d;
        end
    end

    // Parser and finalise-stage registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SYNC;
            flags_q     <= '0;
            len_q       <= '0;
            time_q      <= '0;
            run_q       <= 1'b0;
            en_q        <= '0;
            fin_v_q     <= 1'b0;
            fin_match_q <= '0;
            fin_len_q   <= '0;
            fin_time_q  <= '0;
        end else begin
            state_q     <= state_d;
            flags_q     <= flags_d;
            len_q       <= len_d;
            time_q      <= time_d;
            run_q       <= run_d;
            en_q        <= en_d;
            fin_v_q     <= fin_v_d;
            fin_match_q <= fin_match_d;
            fin_len_q   <= fin_len_d;
            fin_time_q  <= fin_time_d;
        end
    end

    // Event FIFO control: a pop frees the slot for a same-cycle push when full
    always_comb begin
        evt_pop  = m_evt_valid && m_evt_ready;
        evt_full = (cnt_q == DEPTH_C);
        evt_push = fin_v_q && (!evt_full || evt_pop);
        wr_ptr_d = evt_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = evt_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(evt_push) - CW'(evt_pop);
    end

    // Event FIFO storage
    always_ff @(posedge clk) begin
        if (evt_push) begin
            evt_match_mem[wr_ptr_q] <= fin_match_q;
            evt_len_mem[wr_ptr_q]   <= fin_len_q;
            evt_time_mem[wr_ptr_q]  <= fin_time_q;
        end
    end

    // Event FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Head entry is gated so outputs read zero whenever the FIFO is empty
    assign m_evt_valid  = (cnt_q != '0);
    assign m_evt_match  = m_evt_valid ? evt_match_mem[rd_ptr_q] : '0;
    assign m_evt_length = m_evt_valid ? evt_len_mem[rd_ptr_q]   : '0;
    assign m_evt_time   = m_evt_valid ? evt_time_mem[rd_ptr_q]  : '0;

`ifdef ETH_PATTERN_MATCHER_DROP_CNT_EN
    logic        evt_drop;
    logic [31:0] drop_q, drop_d;

    // Saturating count of events discarded at a full FIFO
    always_comb begin
        evt_drop = fin_v_q && evt_full && !evt_pop;
        drop_d   = (evt_drop && (drop_q != '1)) ? drop_q + 32'd1 : drop_q;
    end

    // Drop counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_eth_pattern_matcher.sv
// tb_eth_pattern_matcher: directed plus randomized checks of eth_pattern_matcher
// against a frame-level reference model (queues of bytes/events).
module tb_eth_pattern_matcher;

    localparam int NP    = 4;
    localparam int PL    = 64;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [5:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic [7:0]  cfg_mask;
    logic [3:0]  cfg_enable;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tuser;
    logic        s_axis_tlast;
    logic        s_axis_tvalid;
    logic [63:0] current_time;
    logic        time_running;
    logic        m_evt_valid;
    logic        m_evt_ready;
    logic [3:0]  m_evt_match;
    logic [15:0] m_evt_length;
    logic [63:0] m_evt_time;
    logic [31:0] drop_count;

    eth_pattern_matcher #(
        .NUM_PATTERNS(NP),
        .PATTERN_LEN (PL),
        .EVT_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_sel      (cfg_sel),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_mask     (cfg_mask),
        .cfg_enable   (cfg_enable),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid),
        .current_time (current_time),
        .time_running (time_running),
        .m_evt_valid  (m_evt_valid),
        .m_evt_ready  (m_evt_ready),
        .m_evt_match  (m_evt_match),
        .m_evt_length (m_evt_length),
        .m_evt_time   (m_evt_time),
        .drop_count   (drop_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] drop_lit(input int n);
`ifdef ETH_PATTERN_MATCHER_DROP_CNT_EN
        return 32'(n);
`else
        return 32'd0;
`endif
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  match;
        logic [15:0] len;
        logic [63:0] t;
    } evt_t;

    logic [7:0] pat_m [NP][PL];
    logic [7:0] msk_m [NP][PL];
    evt_t       fifo_m[$];
    evt_t       pend;
    bit         pend_v     = 1'b0;
    bit         sync_m     = 1'b1;
    bit         in_frame_m = 1'b0;
    int         nbytes_m   = 0;
    logic [3:0] flags_m, en_m;
    logic [63:0] t_m;
    bit         run_m;
    longint     drops_m    = 0;

    // Frame-level model: bytes accumulate into flags, events wait one edge
    // before entering the queue, queue holds at most DEPTH events.
    always @(posedge clk) begin
        if (rst) begin
            sync_m     = 1'b1;
            in_frame_m = 1'b0;
            pend_v     = 1'b0;
            drops_m    = 0;
            fifo_m.delete();
        end else begin
            if (fifo_m.size() != 0 && m_evt_ready) fifo_m.delete(0);
            if (pend_v) begin
                if (fifo_m.size() < DEPTH) fifo_m.push_back(pend);
                else if (drops_m < 64'hFFFF_FFFF) drops_m++;
            end
            pend_v = 1'b0;
            if (s_axis_tvalid) begin
                if (sync_m) begin
                    if (s_axis_tlast) sync_m = 1'b0;
                end else begin
                    if (!in_frame_m) begin
                        in_frame_m = 1'b1;
                        nbytes_m   = 0;
                        flags_m    = '1;
                        en_m       = cfg_enable;
                        t_m        = current_time;
                        run_m      = time_running;
                    end
                    if (nbytes_m < PL) begin
                        for (int p = 0; p < NP; p++) begin
                            if (((s_axis_tdata ^ pat_m[p][nbytes_m]) & msk_m[p][nbytes_m]) != 8'h00)
                                flags_m[p] = 1'b0;
                        end
                    end
                    nbytes_m++;
                    if (s_axis_tlast) begin
                        in_frame_m = 1'b0;
                        if ((flags_m & en_m) != 4'b0 && !s_axis_tuser && run_m) begin
                            pend_v     = 1'b1;
                            pend.match = flags_m & en_m;
                            pend.len   = (nbytes_m > 65535) ? 16'hFFFF : 16'(nbytes_m);
                            pend.t     = t_m;
                        end
                    end
                end
            end
        end
        if (cfg_we) begin
            pat_m[cfg_sel][cfg_addr] = cfg_data;
            msk_m[cfg_sel][cfg_addr] = cfg_mask;
        end
    end

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("evt_valid", {63'd0, m_evt_valid}, {63'd0, fifo_m.size() != 0});
            if (m_evt_valid && fifo_m.size() != 0) begin
                chk("evt_match", {60'd0, m_evt_match}, {60'd0, fifo_m[0].match});
                chk("evt_length", {48'd0, m_evt_length}, {48'd0, fifo_m[0].len});
                chk("evt_time", m_evt_time, fifo_m[0].t);
            end
`ifdef ETH_PATTERN_MATCHER_DROP_CNT_EN
            chk("drop_count", {32'd0, drop_count}, 64'(drops_m));
`else
            chk("drop_count", {32'd0, drop_count}, 64'd0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    logic [63:0] tnow     = 64'd0;
    bit          rst_v    = 1'b1;
    bit          ready_v  = 1'b0;
    bit          tr_v     = 1'b1;
    logic [3:0]  en_v     = 4'b0001;
    bit          rand_mode = 1'b0;
    bit          cfg_pend = 1'b0;
    logic [1:0]  cp_sel;
    logic [5:0]  cp_addr;
    logic [7:0]  cp_data, cp_mask;

    task automatic drive(input bit v, input logic [7:0] d, input bit l, input bit u);
        @(negedge clk);
        #1;
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        rst           = rst_v;
        m_evt_ready   = rand_mode ? 1'($urandom_range(1)) : ready_v;
        time_running  = tr_v;
        cfg_enable    = en_v;
        current_time  = tnow;
        tnow          = tnow + 64'd1;
        cfg_we        = 1'b0;
        if (cfg_pend) begin
            cfg_we   = 1'b1;
            cfg_sel  = cp_sel;
            cfg_addr = cp_addr;
            cfg_data = cp_data;
            cfg_mask = cp_mask;
            cfg_pend = 1'b0;
        end else if (rand_mode && $urandom_range(15) == 0) begin
            cfg_we   = 1'b1;
            cfg_sel  = 2'($urandom_range(3));
            cfg_addr = 6'($urandom_range(63));
            cfg_data = ($urandom_range(1) == 1) ? {cfg_sel, cfg_addr} : 8'($urandom);
            cfg_mask = ($urandom_range(1) == 1) ? 8'hFF : 8'($urandom);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [5:0] addr,
                             input logic [7:0] data, input logic [7:0] mask);
        cfg_pend = 1'b1;
        cp_sel   = sel;
        cp_addr  = addr;
        cp_data  = data;
        cp_mask  = mask;
        idle(1);
    endtask

    // Byte k of a frame is k ^ xr (low 8 bits), so xr = p*0x40 matches pattern p
    task automatic send_frame(input int len, input logic [7:0] xr = 8'h00,
                              input bit user = 1'b0, input int bad_idx = -1,
                              input logic [7:0] bad_val = 8'h00,
                              input int rst_at = -1, input int en_at = -1);
        for (int k = 0; k < len; k++) begin
            logic [7:0] d;
            d = 8'(k) ^ xr;
            if (k == bad_idx) d = bad_val;
            if (rst_at >= 0) rst_v = (k >= rst_at) && (k < rst_at + 2);
            if (k == en_at) en_v = 4'b1011;
            if (rand_mode && $urandom_range(7) == 0) idle(1);
            drive(1'b1, d, k == len - 1, (k == len - 1) ? user : 1'b0);
        end
        if (rst_at >= 0) rst_v = 1'b0;
    endtask

    task automatic pop_all();
        ready_v = 1'b1;
        idle(6);
        ready_v = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_addr = '0; cfg_data = '0; cfg_mask = '0;
        cfg_enable = 4'b0001; s_axis_tdata = '0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
        s_axis_tvalid = 1'b0; current_time = '0; time_running = 1'b1; m_evt_ready = 1'b0;

        // Pattern p byte k = {p, k}, full mask; loaded while held in reset
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < PL; k++)
                cfg_write(2'(p), 6'(k), {2'(p), 6'(k)}, 8'hFF);
        idle(2);
        chk_en = 1'b1;
        idle(1);
        chk("rst_valid", {63'd0, m_evt_valid}, 64'd0);
        chk("rst_match", {60'd0, m_evt_match}, 64'd0);
        chk("rst_length", {48'd0, m_evt_length}, 64'd0);
        chk("rst_time", m_evt_time, 64'd0);
        chk("rst_drop", {32'd0, drop_count}, 64'd0);

        rst_v = 1'b0;
        idle(1);
        // First frame only brings the parser out of SYNC
        send_frame(3);
        idle(3);
        chk("sync_no_evt", {63'd0, m_evt_valid}, 64'd0);

        // 64-byte matching frame, timestamp 0x1000 on first byte
        tnow = 64'h1000;
        send_frame(64);
        idle(1);
        chk("t1_valid_early", {63'd0, m_evt_valid}, 64'd0);
        idle(1);
        chk("t1_valid", {63'd0, m_evt_valid}, 64'd1);
        chk("t1_match", {60'd0, m_evt_match}, 64'h1);
        chk("t1_length", {48'd0, m_evt_length}, 64'd64);
        chk("t1_time", m_evt_time, 64'h1000);
        chk("model_depth", 64'(fifo_m.size()), 64'd1);
        if (fifo_m.size() != 0) begin
            chk("model_len", {48'd0, fifo_m[0].len}, 64'd64);
            chk("model_time", fifo_m[0].t, 64'h1000);
        end
        pop_all();

        // Corrupted byte 5, then masked out
        send_frame(64, 8'h00, 1'b0, 5, 8'hAA);
        idle(3);
        chk("bad_no_evt", {63'd0, m_evt_valid}, 64'd0);
        cfg_write(2'd0, 6'd5, 8'h05, 8'h00);
        send_frame(64, 8'h00, 1'b0, 5, 8'hAA);
        idle(2);
        chk("masked_valid", {63'd0, m_evt_valid}, 64'd1);
        chk("masked_match", {60'd0, m_evt_match}, 64'h1);
        pop_all();
        cfg_write(2'd0, 6'd5, 8'h05, 8'hFF);

        // Length boundaries
        send_frame(1);
        idle(2);
        chk("len1", {48'd0, m_evt_length}, 64'd1);
        pop_all();
        send_frame(70000);
        idle(2);
        chk("len_sat", {48'd0, m_evt_length}, 64'd65535);
        pop_all();

        // Error frame and timer stopped
        send_frame(20, 8'h00, 1'b1);
        idle(3);
        chk("tuser_no_evt", {63'd0, m_evt_valid}, 64'd0);
        tr_v = 1'b0;
        send_frame(20);
        tr_v = 1'b1;
        idle(3);
        chk("notime_no_evt", {63'd0, m_evt_valid}, 64'd0);

        // Backpressure: 6 back-to-back frames into a 4-deep FIFO
        for (int i = 0; i < 6; i++) send_frame(8);
        idle(2);
        chk("bp_drop", {32'd0, drop_count}, {32'd0, drop_lit(2)});
        chk("bp_valid", {63'd0, m_evt_valid}, 64'd1);
        send_frame(8);
        ready_v = 1'b1;
        idle(1);
        ready_v = 1'b0;
        idle(1);
        chk("bp_pushpop_drop", {32'd0, drop_count}, {32'd0, drop_lit(2)});
        pop_all();
        chk("bp_drained", {63'd0, m_evt_valid}, 64'd0);

        // Reset in the middle of a frame, with an event already queued
        send_frame(8);
        idle(2);
        send_frame(20, 8'h00, 1'b0, -1, 8'h00, 10);
        idle(3);
        chk("rstmid_no_evt", {63'd0, m_evt_valid}, 64'd0);
        chk("rstmid_drop", {32'd0, drop_count}, 64'd0);
        send_frame(64);
        idle(2);
        chk("rstmid_next_valid", {63'd0, m_evt_valid}, 64'd1);
        chk("rstmid_next_match", {60'd0, m_evt_match}, 64'h1);
        pop_all();

        // Pattern 2 only, all enabled; then disable it mid-frame
        en_v = 4'b1111;
        send_frame(64, 8'h80);
        idle(2);
        chk("p2_match", {60'd0, m_evt_match}, 64'h4);
        pop_all();
        en_v = 4'b1111;
        send_frame(64, 8'h80, 1'b0, -1, 8'h00, -1, 10);
        idle(2);
        chk("p2_latched_en", {60'd0, m_evt_match}, 64'h4);
        pop_all();

        // Randomized frames, checked by the per-cycle compare
        rand_mode = 1'b1;
        for (int f = 0; f < 200; f++) begin
            int         len, bad, ra;
            logic [7:0] xr;
            len  = $urandom_range(1, 60);
            xr   = ($urandom_range(4) == 0) ? 8'($urandom) : {2'($urandom_range(3)), 6'd0};
            en_v = 4'($urandom);
            tr_v = ($urandom_range(7) != 0);
            bad  = ($urandom_range(3) == 0) ? $urandom_range(len - 1) : -1;
            ra   = ($urandom_range(49) == 0 && len > 3) ? $urandom_range(len - 3) : -1;
            send_frame(len, xr, ($urandom_range(7) == 0), bad, 8'($urandom), ra);
            idle($urandom_range(2));
        end
        rand_mode = 1'b0;
        tr_v      = 1'b1;
        ready_v   = 1'b1;
        idle(10);
        chk("final_empty", {63'd0, m_evt_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
